tlp_rx_axi_bridge: RTL
======================

Name: tlp_rx_axi_bridge

Overview:
- Consumes single-beat memory-request TLPs (4DW header plus up to 8DW payload) from the TLP transmit-side source, which is the stage directly upstream.
- Decodes each header and issues one AXI transaction per TLP on a simplified single-beat master port: a write (AW/W/B) for MWr, or a read address (AR) for MRd.
- Unsupported or malformed TLPs are dropped and counted.

Parameters:
- DOUBLE_WORD, 32, width of one DW in bits.
- HEADER_SIZE, 4*DOUBLE_WORD, header width. DW0 occupies [127:96], DW3 occupies [31:0].
- PAYLOAD_SIZE, 8*DOUBLE_WORD, payload width. Payload DWi occupies [32i+31:32i].
- MAX_DW, 8, largest accepted Length field value.
- SOP_EOP_CHECK, 0, when 1 a beat is accepted as a TLP only if in_sop and in_eop are both 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_ready  out  1  bridge can accept a TLP beat.
- in_data  in  PAYLOAD_SIZE  TLP payload.
- in_hdr  in  HEADER_SIZE  TLP header.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_valid  in  1  beat valid.
- m_awaddr  out  64  write address.
- m_awvalid  out  1  write address valid.
- m_awready  in  1  write address ready.
- m_wdata  out  PAYLOAD_SIZE  write data.
- m_wstrb  out  PAYLOAD_SIZE/8  byte strobes.
- m_wvalid  out  1  write data valid.
- m_wready  in  1  write data ready.
- m_bresp  in  2  write response code.
- m_bvalid  in  1  write response valid.
- m_bready  out  1  write response ready.
- m_araddr  out  64  read address.
- m_arid  out  8  read ID; carries the TLP Tag.
- m_arvalid  out  1  read address valid.
- m_arready  in  1  read address ready.
- unsup_cnt  out  16  count of dropped TLPs; saturates at 0xFFFF.
- bresp_err_cnt  out  16  count of responses with m_bresp != 0; saturates at 0xFFFF.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and both counters are 0. The reset takes effect on the first clock edge at which rst=1.
- Reset asserted mid-transaction: all valids drop at that edge and the transaction is abandoned; no counter changes.
- FSM states: IDLE, DECODE, WR, WAIT_B, RD.
- in_ready is 1 only in IDLE. It is registered and always deasserts for at least 2 cycles after an accept, because the upstream source advances to its next TLP on the rising edge of in_ready.
- IDLE: a beat is accepted when in_valid and in_ready are both 1 at the clock edge. The header and payload are latched and the FSM moves to DECODE.
- Beat gating when SOP_EOP_CHECK=1: a beat with in_valid=1 but missing sop or eop is accepted, counted in unsup_cnt, and the FSM stays in IDLE.
- DECODE (1 cycle) extracts these fields:
  - fmt = hdr[127:125]
  - type = hdr[124:120]
  - len = hdr[105:96]
  - tag = hdr[79:72]
  - addr = {hdr[63:2], 2'b00}
- DECODE outcomes:
  - fmt=011 and type=00000 is MWr: go to WR.
  - fmt=001 and type=00000 is MRd: go to RD.
  - Any other fmt/type, or len=0 (encodes 1024 DW), or len>MAX_DW: increment unsup_cnt and return to IDLE.
- Latency: for an accept at edge N, m_awvalid/m_wvalid or m_arvalid is high after edge N+2.
- WR: m_awvalid and m_wvalid assert together. Each one drops independently on its own ready handshake. The FSM moves to WAIT_B once both handshakes are done, which may complete in the same cycle or in different cycles. Values are held stable while valid is high.
- WR data outputs:
  - m_awaddr = addr.
  - m_wdata = latched payload.
  - m_wstrb has its low 4*len bits set and all others 0 (for example, len=3 gives 0x00000FFF).
- WAIT_B: m_bready=1. On m_bvalid, increment bresp_err_cnt if m_bresp != 0, then go to IDLE.
- RD: m_arvalid=1, m_araddr=addr, m_arid=tag. On m_arready, go to IDLE. No read data is returned by this block.
- Counter saturation: each counter holds at 0xFFFF.
- Payload DWs beyond len are forwarded unchanged but their strobes are 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 → all outputs 0 during reset; in_ready=1 from the first cycle after reset.
- MWr, ready held high: hdr fmt=011, type=0, len=2, addr=0x0000_0001_0000_1004, data DW0=0xA5A5A5A5 → m_awaddr=0x0000000100001004, m_wstrb=0x000000FF, valids high 2 cycles after accept; bvalid with bresp=0 → return to IDLE with bresp_err_cnt=0.
- MRd with stalls: fmt=001, len=1, tag=0x3C, addr low bits 0x...7 → m_araddr low bits 0x...4, m_arid=0x3C; arready low for 5 cycles → m_arvalid and m_araddr held stable, in_ready stays 0 throughout.
- Split AW/W handshake: m_awready on cycle 1, m_wready on cycle 4 → m_awvalid drops after cycle 1, m_wvalid drops after cycle 4, m_bready asserts only after both; bresp=2'b10 → bresp_err_cnt=1.
- Drops: fmt=011 with len=0; then len=9; then type=00100 → unsup_cnt=3, no AXI valid ever asserts, in_ready returns after 2 low cycles each time.
- Reset mid-WR: assert rst while m_awvalid=1 and awready=0 → all valids 0 after that edge, counters 0, FSM in IDLE.

Source files
------------

// File: rtl/tlp_rx_axi_bridge.sv
// Receive-side bridge: decodes single-beat MWr/MRd TLPs and issues one
// single-beat AXI write (AW/W/B) or read address (AR) per TLP.
module tlp_rx_axi_bridge #(
    parameter int DOUBLE_WORD   = 32,
    parameter int HEADER_SIZE   = 4*DOUBLE_WORD,
    parameter int PAYLOAD_SIZE  = 8*DOUBLE_WORD,
    parameter int MAX_DW        = 8,
    parameter int SOP_EOP_CHECK = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      in_ready,
    input  logic [PAYLOAD_SIZE-1:0]   in_data,
    input  logic [HEADER_SIZE-1:0]    in_hdr,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic                      in_valid,
    output logic [63:0]               m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [PAYLOAD_SIZE-1:0]   m_wdata,
    output logic [PAYLOAD_SIZE/8-1:0] m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [63:0]               m_araddr,
    output logic [7:0]                m_arid,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [15:0]               unsup_cnt,
    output logic [15:0]               bresp_err_cnt
);

    localparam int NUM_DW       = PAYLOAD_SIZE / DOUBLE_WORD;
    localparam int BYTES_PER_DW = DOUBLE_WORD / 8;

    typedef enum logic [2:0] {IDLE, DECODE, WR, WAIT_B, RD} state_t;

    state_t state_q, state_d;
    logic [2:0] fmt_q;
    logic [4:0] typ_q;
    logic [9:0] len_q;
    logic       issued_q, issued_d;
    logic       accept_q;
    logic       awvalid_d, wvalid_d, arvalid_d, in_ready_d;
    logic       accept, load_beat, unsup_inc, berr_inc;
    logic       is_mwr, is_mrd, len_ok;
    logic [PAYLOAD_SIZE/8-1:0] strb_in;
    logic       unused_hdr;

    assign unused_hdr = ^{in_hdr[119:106], in_hdr[95:80], in_hdr[71:64], in_hdr[1:0]};
    assign m_bready   = (state_q == WAIT_B);

    assign accept = in_valid && in_ready;
    assign is_mwr = (fmt_q == 3'b011) && (typ_q == 5'b00000);
    assign is_mrd = (fmt_q == 3'b001) && (typ_q == 5'b00000);
    assign len_ok = (len_q != 10'd0) && (len_q <= 10'(MAX_DW));

    always_comb begin
        strb_in = '0;
        for (int unsigned i = 0; i < NUM_DW; i++) begin
            strb_in[i*BYTES_PER_DW +: BYTES_PER_DW] = (i < 32'(in_hdr[105:96])) ? '1 : '0;
        end
    end

    // Valids launch one cycle after entering WR/RD (issued_q) so they appear
    // two edges after accept; each then drops on its own handshake.
    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        awvalid_d = m_awvalid;
        wvalid_d  = m_wvalid;
        arvalid_d = m_arvalid;
        load_beat = 1'b0;
        unsup_inc = 1'b0;
        berr_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (SOP_EOP_CHECK != 0 && !(in_sop && in_eop)) begin
                        unsup_inc = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                        state_d   = DECODE;
                    end
                end
            end
            DECODE: begin
                issued_d = 1'b0;
                if (is_mwr && len_ok)      state_d = WR;
                else if (is_mrd && len_ok) state_d = RD;
                else begin
                    unsup_inc = 1'b1;
                    state_d   = IDLE;
                end
            end
            WR: begin
                if (!issued_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    issued_d  = 1'b1;
                end else begin
                    awvalid_d = m_awvalid && !m_awready;
                    wvalid_d  = m_wvalid && !m_wready;
                    if (!awvalid_d && !wvalid_d) state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (m_bvalid) begin
                    berr_inc = (m_bresp != 2'b00);
                    state_d  = IDLE;
                end
            end
            RD: begin
                if (!issued_q) begin
                    arvalid_d = 1'b1;
                    issued_d  = 1'b1;
                end else begin
                    arvalid_d = m_arvalid && !m_arready;
                    if (!arvalid_d) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // accept_q stretches the low phase to two cycles even for in-IDLE drops
        in_ready_d = (state_d == IDLE) && !accept && !accept_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fmt_q         <= '0;
            typ_q         <= '0;
            len_q         <= '0;
            issued_q      <= 1'b0;
            accept_q      <= 1'b0;
            in_ready      <= 1'b0;
            m_awvalid     <= 1'b0;
            m_wvalid      <= 1'b0;
            m_arvalid     <= 1'b0;
            m_awaddr      <= '0;
            m_araddr      <= '0;
            m_arid        <= '0;
            m_wdata       <= '0;
            m_wstrb       <= '0;
            unsup_cnt     <= '0;
            bresp_err_cnt <= '0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            accept_q  <= accept;
            in_ready  <= in_ready_d;
            m_awvalid <= awvalid_d;
            m_wvalid  <= wvalid_d;
            m_arvalid <= arvalid_d;
            if (load_beat) begin
                fmt_q    <= in_hdr[127:125];
                typ_q    <= in_hdr[124:120];
                len_q    <= in_hdr[105:96];
                m_awaddr <= {in_hdr[63:2], 2'b00};
                m_araddr <= {in_hdr[63:2], 2'b00};
                m_arid   <= in_hdr[79:72];
                m_wdata  <= in_data;
                m_wstrb  <= strb_in;
            end
            if (unsup_inc && unsup_cnt != 16'hFFFF) unsup_cnt <= unsup_cnt + 16'd1;
            if (berr_inc && bresp_err_cnt != 16'hFFFF) bresp_err_cnt <= bresp_err_cnt + 16'd1;
        end
    end

endmodule
